// File: rtl/cr_xp10_decomp_hufd_bank_ctl_pkg.sv
// cr_xp10_decompPKG: shared types for the Huffman decoder bank controller.
package cr_xp10_decompPKG;
  localparam int N_BANKS_DFLT = 2;
  typedef enum logic [1:0] {BANK_FREE, BANK_FILL, BANK_READY, BANK_ACTIVE} bank_state_e;
  typedef enum logic [1:0] {FMT_XP10, FMT_XP9, FMT_DEFLATE, FMT_ZLIB} htf_fmt_e;
  typedef struct packed {
    logic [5:0] blk_id;
    logic       eob;
    logic       last;
  } sched_info_t;
endpackage

// File: rtl/cr_xp10_decomp_hufd_bank_ctl_fifo.sv
// cr_xp10_decomp_hufd_bank_fifo: small circular FIFO holding bank indices in completion order.
module cr_xp10_decomp_hufd_bank_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign pop_data = mem_q[rd_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = push_data;
    wr_d  = push_ok ? inc(wr_q) : wr_q;
    rd_d  = pop_ok ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cr_xp10_decomp_hufd_bank_ctl.sv
// cr_xp10_decomp_hufd_bank_ctl: hands Huffman table banks from the builder (htf) to the decoder (sdd)
// through FREE -> FILL -> READY -> ACTIVE -> FREE ownership states.
module cr_xp10_decomp_hufd_bank_ctl
  import cr_xp10_decompPKG::*;
#(
  parameter int N_BANKS = N_BANKS_DFLT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       htf_alloc_valid,
  output logic                       htf_alloc_ready,
  output logic [$clog2(N_BANKS)-1:0] htf_alloc_bank,
  input  logic                       htf_complete_valid,
  input  htf_fmt_e                   htf_complete_fmt,
  input  logic                       htf_complete_error,
  input  sched_info_t                htf_complete_sched_info,
  output logic                       sdd_tbl_valid,
  output logic [$clog2(N_BANKS)-1:0] sdd_tbl_bank,
  output htf_fmt_e                   sdd_tbl_fmt,
  output logic                       sdd_tbl_error,
  output sched_info_t                sdd_tbl_sched_info,
  input  logic                       sdd_tbl_ready,
  input  logic                       sdd_release,
  output logic                       sdd_htf_busy,
  output logic                       bank_err_stb,
  output logic                       bank_stall_stb
);
  localparam int BW = $clog2(N_BANKS);
  bank_state_e          st_q [N_BANKS];
  bank_state_e          st_d [N_BANKS];
  htf_fmt_e             fmt_q [N_BANKS];
  htf_fmt_e             fmt_d [N_BANKS];
  sched_info_t          si_q [N_BANKS];
  sched_info_t          si_d [N_BANKS];
  logic [N_BANKS-1:0]   err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 any_free, any_fill, any_active;
  logic [BW-1:0]        free_idx, fill_idx, act_idx, head;
  logic                 fifo_empty, fifo_full;
  logic                 alloc_fire, cmpl_ok, acc_fire, rel_ok;
  // Descending scan so the lowest matching index wins.
  always_comb begin
    any_free   = 1'b0;
    any_fill   = 1'b0;
    any_active = 1'b0;
    free_idx   = '0;
    fill_idx   = '0;
    act_idx    = '0;
    for (int i = N_BANKS - 1; i >= 0; i--) begin
      if (st_q[i] == BANK_FREE) begin any_free = 1'b1; free_idx = BW'(i); end
      if (st_q[i] == BANK_FILL) begin any_fill = 1'b1; fill_idx = BW'(i); end
      if (st_q[i] == BANK_ACTIVE) begin any_active = 1'b1; act_idx = BW'(i); end
    end
  end
  always_comb begin
    htf_alloc_ready    = any_free & ~any_fill;
    htf_alloc_bank     = free_idx;
    sdd_tbl_valid      = ~fifo_empty & ~any_active;
    sdd_tbl_bank       = sdd_tbl_valid ? head : '0;
    sdd_tbl_fmt        = sdd_tbl_valid ? fmt_q[head] : FMT_XP10;
    sdd_tbl_error      = sdd_tbl_valid & err_q[head];
    sdd_tbl_sched_info = sdd_tbl_valid ? si_q[head] : '0;
    sdd_htf_busy       = busy_q;
    bank_err_stb       = (htf_complete_valid & ~any_fill) | (sdd_release & ~any_active);
    bank_stall_stb     = htf_alloc_valid & ~htf_alloc_ready;
    alloc_fire         = htf_alloc_valid & htf_alloc_ready;
    cmpl_ok            = htf_complete_valid & any_fill & ~fifo_full;
    acc_fire           = sdd_tbl_valid & sdd_tbl_ready;
    rel_ok             = sdd_release & any_active;
  end
  always_comb begin
    st_d  = st_q;
    fmt_d = fmt_q;
    si_d  = si_q;
    err_d = err_q;
    if (alloc_fire) st_d[free_idx] = BANK_FILL;
    if (cmpl_ok) begin
      st_d[fill_idx]  = BANK_READY;
      fmt_d[fill_idx] = htf_complete_fmt;
      si_d[fill_idx]  = htf_complete_sched_info;
      err_d[fill_idx] = htf_complete_error;
    end
    if (acc_fire) st_d[head] = BANK_ACTIVE;
    if (rel_ok) st_d[act_idx] = BANK_FREE;
    busy_d = 1'b1;
    for (int i = 0; i < N_BANKS; i++)
      if (st_d[i] == BANK_FREE) busy_d = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= '{default: BANK_FREE};
      fmt_q  <= '{default: FMT_XP10};
      si_q   <= '{default: '0};
      err_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      fmt_q  <= fmt_d;
      si_q   <= si_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  cr_xp10_decomp_hufd_bank_fifo #(.DEPTH(N_BANKS), .W(BW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmpl_ok),
    .push_data (fill_idx),
    .pop       (acc_fire),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_cr_xp10_decomp_hufd_bank_ctl.sv
// tb_cr_xp10_decomp_hufd_bank_ctl: directed vector table on a 2-bank instance, model-checked random run
// and asynchronous reset sequence on a 3-bank instance.
module tb_cr_xp10_decomp_hufd_bank_ctl;
  import cr_xp10_decompPKG::*;
  localparam int NB3 = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic av = 0, cv = 0, cerr = 0, rdy = 0, rel = 0;
  htf_fmt_e cfmt = FMT_XP10;
  sched_info_t csi = '0;
  logic r2, v2, e2, busy2, err2, stall2;
  logic [0:0] b2, tb2;
  htf_fmt_e f2;
  sched_info_t s2;
  logic r3, v3, e3, busy3, err3, stall3;
  logic [1:0] b3, tb3;
  htf_fmt_e f3;
  sched_info_t s3;
  int tests = 0, fails = 0;

  cr_xp10_decomp_hufd_bank_ctl #(.N_BANKS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .htf_alloc_valid(av), .htf_alloc_ready(r2), .htf_alloc_bank(b2),
    .htf_complete_valid(cv), .htf_complete_fmt(cfmt), .htf_complete_error(cerr),
    .htf_complete_sched_info(csi), .sdd_tbl_valid(v2), .sdd_tbl_bank(tb2), .sdd_tbl_fmt(f2),
    .sdd_tbl_error(e2), .sdd_tbl_sched_info(s2), .sdd_tbl_ready(rdy), .sdd_release(rel),
    .sdd_htf_busy(busy2), .bank_err_stb(err2), .bank_stall_stb(stall2));
  cr_xp10_decomp_hufd_bank_ctl #(.N_BANKS(NB3)) dut3 (
    .clk(clk), .rst_n(rst_n), .htf_alloc_valid(av), .htf_alloc_ready(r3), .htf_alloc_bank(b3),
    .htf_complete_valid(cv), .htf_complete_fmt(cfmt), .htf_complete_error(cerr),
    .htf_complete_sched_info(csi), .sdd_tbl_valid(v3), .sdd_tbl_bank(tb3), .sdd_tbl_fmt(f3),
    .sdd_tbl_error(e3), .sdd_tbl_sched_info(s3), .sdd_tbl_ready(rdy), .sdd_release(rel),
    .sdd_htf_busy(busy3), .bank_err_stb(err3), .bank_stall_stb(stall3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which bank is being filled, which is owned by sdd, and a queue of completed banks.
  int m_fill = -1, m_act = -1;
  int m_rq[$];
  htf_fmt_e m_fmt [NB3];
  logic m_err [NB3];
  sched_info_t m_si [NB3];
  logic m_busy = 1'b0;

  function automatic bit is_free(int b);
    if (b == m_fill || b == m_act) return 1'b0;
    foreach (m_rq[k]) if (m_rq[k] == b) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int low_free();
    for (int b = 0; b < NB3; b++) if (is_free(b)) return b;
    return -1;
  endfunction
  function automatic void model_reset();
    m_fill = -1;
    m_act  = -1;
    m_rq.delete();
    m_busy = 1'b0;
  endfunction
  task automatic model_check();
    int lf, hb;
    bit e_rdy, e_val;
    lf    = low_free();
    e_rdy = (lf >= 0) && (m_fill < 0);
    e_val = (m_rq.size() > 0) && (m_act < 0);
    hb    = e_val ? m_rq[0] : 0;
    chk("m alloc_ready", 32'(r3), 32'(e_rdy));
    chk("m alloc_bank", 32'(b3), 32'(lf < 0 ? 0 : lf));
    chk("m tbl_valid", 32'(v3), 32'(e_val));
    chk("m tbl_bank", 32'(tb3), 32'(hb));
    chk("m tbl_fmt", 32'(f3), e_val ? 32'(m_fmt[hb]) : 32'(0));
    chk("m tbl_error", 32'(e3), e_val ? 32'(m_err[hb]) : 32'(0));
    chk("m tbl_sched", 32'(s3), e_val ? 32'(m_si[hb]) : 32'(0));
    chk("m busy", 32'(busy3), 32'(m_busy));
    chk("m err_stb", 32'(err3), 32'((cv && m_fill < 0) || (rel && m_act < 0)));
    chk("m stall_stb", 32'(stall3), 32'(av && !e_rdy));
  endtask
  function automatic void model_step();
    int lf, nf, na;
    bit e_rdy, e_val;
    lf    = low_free();
    e_rdy = (lf >= 0) && (m_fill < 0);
    e_val = (m_rq.size() > 0) && (m_act < 0);
    nf    = m_fill;
    na    = m_act;
    if (e_val && rdy) na = m_rq.pop_front();
    if (rel && m_act >= 0) na = -1;
    if (cv && m_fill >= 0) begin
      m_rq.push_back(m_fill);
      m_fmt[m_fill] = cfmt;
      m_err[m_fill] = cerr;
      m_si[m_fill]  = csi;
      nf = -1;
    end
    if (av && e_rdy) nf = lf;
    m_fill = nf;
    m_act  = na;
    m_busy = (low_free() < 0);
  endfunction
  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask
  task automatic idle();
    av = 0; cv = 0; cerr = 0; rdy = 0; rel = 0; cfmt = FMT_XP10; csi = '0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " r2"}, 32'(r2), 1);      chk({tag, " b2"}, 32'(b2), 0);
    chk({tag, " v2"}, 32'(v2), 0);      chk({tag, " tb2"}, 32'(tb2), 0);
    chk({tag, " f2"}, 32'(f2), 0);      chk({tag, " s2"}, 32'(s2), 0);
    chk({tag, " busy2"}, 32'(busy2), 0); chk({tag, " err2"}, 32'(err2), 0);
    chk({tag, " r3"}, 32'(r3), 1);      chk({tag, " b3"}, 32'(b3), 0);
    chk({tag, " v3"}, 32'(v3), 0);      chk({tag, " tb3"}, 32'(tb3), 0);
    chk({tag, " e3"}, 32'(e3), 0);      chk({tag, " s3"}, 32'(s3), 0);
    chk({tag, " busy3"}, 32'(busy3), 0); chk({tag, " stall3"}, 32'(stall3), 0);
  endtask

  // i = {av, cv, cerr, rdy, rel}; x = {alloc_ready, tbl_valid, tbl_error, busy, err_stb, stall_stb}
  typedef struct {
    logic [4:0] i;
    htf_fmt_e   fmt;
    logic [7:0] si;
    logic [5:0] x;
    logic [0:0] xb;
    logic [0:0] xtb;
    htf_fmt_e   xf;
    logic [7:0] xsi;
  } vec_t;
  vec_t vt [16];

  initial begin
    vt[0]  = '{5'b10000, FMT_XP10,    8'h00, 6'b100000, 1'b0, 1'b0, FMT_XP10,    8'h00};
    vt[1]  = '{5'b01000, FMT_XP9,     8'h11, 6'b000000, 1'b1, 1'b0, FMT_XP10,    8'h00};
    vt[2]  = '{5'b10000, FMT_XP10,    8'h00, 6'b110000, 1'b1, 1'b0, FMT_XP9,     8'h11};
    vt[3]  = '{5'b11100, FMT_DEFLATE, 8'h22, 6'b010101, 1'b0, 1'b0, FMT_XP9,     8'h11};
    vt[4]  = '{5'b00000, FMT_XP10,    8'h00, 6'b010100, 1'b0, 1'b0, FMT_XP9,     8'h11};
    vt[5]  = '{5'b00010, FMT_XP10,    8'h00, 6'b010100, 1'b0, 1'b0, FMT_XP9,     8'h11};
    vt[6]  = '{5'b00001, FMT_XP10,    8'h00, 6'b000100, 1'b0, 1'b0, FMT_XP10,    8'h00};
    vt[7]  = '{5'b00000, FMT_XP10,    8'h00, 6'b111000, 1'b0, 1'b1, FMT_DEFLATE, 8'h22};
    vt[8]  = '{5'b00001, FMT_XP10,    8'h00, 6'b111010, 1'b0, 1'b1, FMT_DEFLATE, 8'h22};
    vt[9]  = '{5'b01000, FMT_XP10,    8'h00, 6'b111010, 1'b0, 1'b1, FMT_DEFLATE, 8'h22};
    vt[10] = '{5'b00000, FMT_XP10,    8'h00, 6'b111000, 1'b0, 1'b1, FMT_DEFLATE, 8'h22};
    vt[11] = '{5'b10010, FMT_XP10,    8'h00, 6'b111000, 1'b0, 1'b1, FMT_DEFLATE, 8'h22};
    vt[12] = '{5'b01000, FMT_ZLIB,    8'h33, 6'b000100, 1'b0, 1'b0, FMT_XP10,    8'h00};
    vt[13] = '{5'b10001, FMT_XP10,    8'h00, 6'b000101, 1'b0, 1'b0, FMT_XP10,    8'h00};
    vt[14] = '{5'b10000, FMT_XP10,    8'h00, 6'b110000, 1'b1, 1'b0, FMT_ZLIB,    8'h33};
    vt[15] = '{5'b00000, FMT_XP10,    8'h00, 6'b010100, 1'b0, 1'b0, FMT_ZLIB,    8'h33};

    idle();
    repeat (2) @(posedge clk);
    #1 chk_reset("in_reset");
    rst_n = 1'b1;
    foreach (vt[k]) begin
      {av, cv, cerr, rdy, rel} = vt[k].i;
      cfmt = vt[k].fmt;
      csi  = sched_info_t'(vt[k].si);
      @(negedge clk);
      chk($sformatf("v%0d alloc_ready", k), 32'(r2), 32'(vt[k].x[5]));
      chk($sformatf("v%0d alloc_bank", k), 32'(b2), 32'(vt[k].xb));
      chk($sformatf("v%0d tbl_valid", k), 32'(v2), 32'(vt[k].x[4]));
      chk($sformatf("v%0d tbl_bank", k), 32'(tb2), 32'(vt[k].xtb));
      chk($sformatf("v%0d tbl_fmt", k), 32'(f2), 32'(vt[k].xf));
      chk($sformatf("v%0d tbl_error", k), 32'(e2), 32'(vt[k].x[3]));
      chk($sformatf("v%0d tbl_sched", k), 32'(s2), 32'(vt[k].xsi));
      chk($sformatf("v%0d busy", k), 32'(busy2), 32'(vt[k].x[2]));
      chk($sformatf("v%0d err_stb", k), 32'(err2), 32'(vt[k].x[1]));
      chk($sformatf("v%0d stall_stb", k), 32'(stall2), 32'(vt[k].x[0]));
      @(posedge clk);
      #1;
    end

    idle();
    rst_n = 1'b0;
    model_reset();
    #1 chk_reset("async_a");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      av   = 1'($urandom_range(0, 1));
      rdy  = ($urandom_range(0, 2) != 0);
      cv   = (m_fill >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      rel  = (m_act >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cfmt = htf_fmt_e'($urandom_range(0, 3));
      cerr = 1'($urandom_range(0, 1));
      csi  = sched_info_t'($urandom_range(0, 255));
      cyc();
    end

    // One bank in each of ACTIVE, READY and FILL, then reset mid-cycle.
    idle();
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    av = 1; cyc();
    idle(); cv = 1; cfmt = FMT_XP9; csi = sched_info_t'(8'h5a); cyc();
    idle(); av = 1; rdy = 1; cyc();
    idle(); cv = 1; cerr = 1; cfmt = FMT_ZLIB; csi = sched_info_t'(8'ha5); cyc();
    idle(); av = 1; cyc();
    idle(); cyc();
    chk("pre_rst busy3", 32'(busy3), 1);
    chk("pre_rst v3", 32'(v3), 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset("async_b");
    @(posedge clk);
    #1 rst_n = 1'b1;
    av = 1; cyc();
    av = 0; cyc();
    chk("post_rst fill", 32'(r3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
